// File: rtl/nsc8_control_sequencer_pkg.sv
// Shared definitions for the NSC-8 control sequencer: opcodes, T-state
// encodings and control-word bit positions.
package nsc8_control_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_HALT = 3'd7
  } state_e;

  localparam int CW_PC_OUT     = 0;
  localparam int CW_PC_INC     = 1;
  localparam int CW_PC_LOAD    = 2;
  localparam int CW_MAR_LOAD   = 3;
  localparam int CW_MEM_OUT    = 4;
  localparam int CW_MEM_IN     = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_IR_OUT     = 7;
  localparam int CW_LOAD_A     = 8;
  localparam int CW_LOAD_IMM_A = 9;
  localparam int CW_A_OUT      = 10;
  localparam int CW_B_LOAD     = 11;
  localparam int CW_ALU_OUT    = 12;
  localparam int CW_ALU_SUB    = 13;
  localparam int CW_FLAGS_LOAD = 14;
  localparam int CW_OUT_LOAD   = 15;
  localparam int CW_HALT       = 16;
  localparam int CW_WIDTH      = 17;

  typedef logic [CW_WIDTH-1:0] cw_t;

endpackage

// File: rtl/nsc8_control_sequencer_if.sv
// Control bundle between the sequencer and the NSC-8 datapath.
// master: sequencer (drives strobes + t_state, reads IR and flags)
// slave : datapath  (drives IR and flags, reads strobes)
interface nsc8_control_sequencer_if #(
  parameter int X       = 8,
  parameter int T_WIDTH = 3
);
  logic [X-1:0]       ir_data;
  logic               carry_flag;
  logic               zero_flag;
  logic               pc_out;
  logic               pc_inc;
  logic               pc_load;
  logic               mar_load;
  logic               mem_out;
  logic               mem_in;
  logic               ir_load;
  logic               ir_out;
  logic               load_a;
  logic               load_immediate_a;
  logic               a_out;
  logic               b_load;
  logic               alu_out;
  logic               alu_sub;
  logic               flags_load;
  logic               out_load;
  logic               halt;
  logic [T_WIDTH-1:0] t_state;

  modport master (
    input  ir_data, carry_flag, zero_flag,
    output pc_out, pc_inc, pc_load, mar_load, mem_out, mem_in, ir_load, ir_out,
           load_a, load_immediate_a, a_out, b_load, alu_out, alu_sub,
           flags_load, out_load, halt, t_state
  );

  modport slave (
    output ir_data, carry_flag, zero_flag,
    input  pc_out, pc_inc, pc_load, mar_load, mem_out, mem_in, ir_load, ir_out,
           load_a, load_immediate_a, a_out, b_load, alu_out, alu_sub,
           flags_load, out_load, halt, t_state
  );
endinterface

// File: rtl/nsc8_microcode_rom.sv
// Combinational microcode: maps (T-state, opcode, flags) to a control word.
// Ports: state, opcode, carry_flag, zero_flag in; cw out.
// Each T-state drives at most one bus source.
module nsc8_microcode_rom
  import nsc8_control_sequencer_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output cw_t        cw
);

  always_comb begin
    cw = '0;
    case (state)
      ST_T0: begin
        cw[CW_PC_OUT]   = 1'b1;
        cw[CW_MAR_LOAD] = 1'b1;
      end
      ST_T1: begin
        cw[CW_MEM_OUT] = 1'b1;
        cw[CW_IR_LOAD] = 1'b1;
        cw[CW_PC_INC]  = 1'b1;
      end
      ST_T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OUT]   = 1'b1;
            cw[CW_MAR_LOAD] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OUT]     = 1'b1;
            cw[CW_LOAD_IMM_A] = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = 1'b1;
          end
          // Untaken jumps still put the operand on the bus; nothing loads it.
          OP_JC: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = carry_flag;
          end
          OP_JZ: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = zero_flag;
          end
          OP_OUT: begin
            cw[CW_A_OUT]    = 1'b1;
            cw[CW_OUT_LOAD] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T3: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_MEM_OUT] = 1'b1;
            cw[CW_LOAD_A]  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_MEM_OUT] = 1'b1;
            cw[CW_B_LOAD]  = 1'b1;
            cw[CW_ALU_SUB] = (opcode == OP_SUB);
          end
          OP_STA: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_MEM_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_ALU_OUT]    = 1'b1;
          cw[CW_LOAD_A]     = 1'b1;
          cw[CW_FLAGS_LOAD] = 1'b1;
          cw[CW_ALU_SUB]    = (opcode == OP_SUB);
        end
      end
      ST_HALT: cw[CW_HALT] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/nsc8_control_sequencer.sv
// NSC-8 control sequencer top: T-state register, next-state logic and the
// strobe decode (microcode ROM, forced to all-zero while reset is high).
// Ports: clk, reset (sync, active-high), ctl (master side of the control bundle).
module nsc8_control_sequencer
  import nsc8_control_sequencer_pkg::*;
#(
  parameter int X       = 8,
  parameter int T_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  nsc8_control_sequencer_if.master       ctl
);

  if (X < 8 || (X % 2) != 0) begin : g_bad_width
    $error("nsc8_control_sequencer: X must be even and >= 8");
  end

  state_e     state_q, state_d;
  logic [3:0] opcode;
  cw_t        cw_rom, cw;

  assign opcode = ctl.ir_data[X-1 -: 4];

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_T0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_T0;
    case (state_q)
      ST_T0: state_d = ST_T1;
      ST_T1: state_d = ST_T2;
      ST_T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = ST_T3;
          OP_HLT:                         state_d = ST_HALT;
          default:                        state_d = ST_T0;
        endcase
      end
      ST_T3:   state_d = (opcode == OP_ADD || opcode == OP_SUB) ? ST_T4 : ST_T0;
      ST_T4:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
  end

  nsc8_microcode_rom u_rom (
    .state      (state_q),
    .opcode     (opcode),
    .carry_flag (ctl.carry_flag),
    .zero_flag  (ctl.zero_flag),
    .cw         (cw_rom)
  );

  // Strobes go quiet combinationally while reset is held, not a cycle later.
  always_comb begin
    cw = cw_rom;
    if (reset) cw = '0;
  end

  assign ctl.pc_out           = cw[CW_PC_OUT];
  assign ctl.pc_inc           = cw[CW_PC_INC];
  assign ctl.pc_load          = cw[CW_PC_LOAD];
  assign ctl.mar_load         = cw[CW_MAR_LOAD];
  assign ctl.mem_out          = cw[CW_MEM_OUT];
  assign ctl.mem_in           = cw[CW_MEM_IN];
  assign ctl.ir_load          = cw[CW_IR_LOAD];
  assign ctl.ir_out           = cw[CW_IR_OUT];
  assign ctl.load_a           = cw[CW_LOAD_A];
  assign ctl.load_immediate_a = cw[CW_LOAD_IMM_A];
  assign ctl.a_out            = cw[CW_A_OUT];
  assign ctl.b_load           = cw[CW_B_LOAD];
  assign ctl.alu_out          = cw[CW_ALU_OUT];
  assign ctl.alu_sub          = cw[CW_ALU_SUB];
  assign ctl.flags_load       = cw[CW_FLAGS_LOAD];
  assign ctl.out_load         = cw[CW_OUT_LOAD];
  assign ctl.halt             = cw[CW_HALT];
  assign ctl.t_state          = T_WIDTH'(state_q);

endmodule
